// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_arbiter: the FSM state encoding and the default
// sizes of the memory port and refill block.
package mem_arb_pkg;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_MEM_LAT     = 4;
    localparam int WORD_IDX_W      = $clog2(DEF_BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        IFILL,
        DFILL,
        DWRITE
    } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction, data and memory-side signals of mem_arbiter.
// The master modport is the arbiter's view; slave is the requesters plus memory.
interface mem_arbiter_if import mem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = WORD_IDX_W
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_grant;
    logic              i_data_valid;
    logic [DATA_W-1:0] i_data;
    logic [IDX_W-1:0]  i_word;
    logic              i_done;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_grant;
    logic              d_data_valid;
    logic [DATA_W-1:0] d_data;
    logic [IDX_W-1:0]  d_word;
    logic              d_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
        output i_grant, i_data_valid, i_data, i_word, i_done,
        output d_grant, d_data_valid, d_data, d_word, d_done,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
        input  i_grant, i_data_valid, i_data, i_word, i_done,
        input  d_grant, d_data_valid, d_data, d_word, d_done,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker between the instruction and data requesters;
// remembers which side was granted last and favours the other on a tie.
module mem_arb_rr (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic accept,
    output logic pick_d
);
    logic last_d;

    always_comb begin
        if (i_req && d_req) pick_d = !last_d;
        else                pick_d = d_req;
    end

    always_ff @(posedge clk) begin
        if (rst)         last_d <= 1'b1;
        else if (accept) last_d <= pick_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared pipelined memory behind the I and D paths.
// Define FAIR_ARB_EN for round-robin on simultaneous requests; default is data-first.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int MEM_LAT     = DEF_MEM_LAT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int BLK_W = ADDR_W - IDX_W;

    if (MEM_LAT < 1 || BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) begin : g_bad_cfg
        $error("mem_arbiter: MEM_LAT must be >= 1 and BLOCK_WORDS a power of two >= 2");
    end

    arb_state_t       state;
    logic [BLK_W-1:0] base_blk;
    logic [BLK_W-1:0] req_blk;
    logic [IDX_W:0]   issue_cnt;
    logic [IDX_W-1:0] ret_cnt;
    logic             accept;
    logic             pick_d;
    logic             filling;
    logic             last_ret;

    assign accept = (state == IDLE) && (bus.i_req || bus.d_req);

`ifdef FAIR_ARB_EN
    mem_arb_rr u_rr (
        .clk    (clk),
        .rst    (rst),
        .i_req  (bus.i_req),
        .d_req  (bus.d_req),
        .accept (accept),
        .pick_d (pick_d)
    );
`else
    assign pick_d = bus.d_req;
`endif

    assign req_blk  = pick_d ? bus.d_addr[ADDR_W-1:IDX_W] : bus.i_addr[ADDR_W-1:IDX_W];
    assign filling  = (state == IFILL) || (state == DFILL);
    assign last_ret = filling && bus.mem_rvalid && (ret_cnt == IDX_W'(BLOCK_WORDS - 1));

    // Read returns pass straight through to whichever side owns the refill.
    assign bus.i_data_valid = (state == IFILL) && bus.mem_rvalid;
    assign bus.i_data       = (state == IFILL) ? bus.mem_rdata : '0;
    assign bus.i_word       = (state == IFILL) ? ret_cnt : '0;
    assign bus.i_done       = (state == IFILL) && last_ret;
    assign bus.d_data_valid = (state == DFILL) && bus.mem_rvalid;
    assign bus.d_data       = (state == DFILL) ? bus.mem_rdata : '0;
    assign bus.d_word       = (state == DFILL) ? ret_cnt : '0;
    assign bus.d_done       = (state == DWRITE) || ((state == DFILL) && last_ret);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base_blk      <= '0;
            issue_cnt     <= '0;
            ret_cnt       <= '0;
            bus.i_grant   <= 1'b0;
            bus.d_grant   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (accept && pick_d && bus.d_we) begin
                        state         <= DWRITE;
                        bus.d_grant   <= 1'b1;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                    end else if (accept) begin
                        // First read goes out with the grant, so issue count starts at 1.
                        state        <= pick_d ? DFILL : IFILL;
                        bus.d_grant  <= pick_d;
                        bus.i_grant  <= !pick_d;
                        base_blk     <= req_blk;
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= {req_blk, {IDX_W{1'b0}}};
                        issue_cnt    <= (IDX_W + 1)'(1);
                        ret_cnt      <= '0;
                    end
                end
                IFILL, DFILL: begin
                    if (issue_cnt < (IDX_W + 1)'(BLOCK_WORDS)) begin
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= {base_blk, issue_cnt[IDX_W-1:0]};
                        issue_cnt    <= issue_cnt + 1'b1;
                    end
                    if (bus.mem_rvalid) ret_cnt <= ret_cnt + 1'b1;
                    if (last_ret) begin
                        state       <= IDLE;
                        bus.i_grant <= 1'b0;
                        bus.d_grant <= 1'b0;
                        issue_cnt   <= '0;
                    end
                end
                DWRITE: begin
                    state       <= IDLE;
                    bus.d_grant <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
